// File: rtl/mipi_rx_pkg.sv
// mipi_rx_pkg: shared definitions for the MIPI CSI-2 RAW unpacker.
// Packet-type codes, bytes-per-group lookup and FSM state encoding.
package mipi_rx_pkg;

    localparam logic [2:0] PT_RAW8  = 3'd2;
    localparam logic [2:0] PT_RAW10 = 3'd3;
    localparam logic [2:0] PT_RAW12 = 3'd4;
    localparam logic [2:0] PT_RAW14 = 3'd5;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_ACTIVE  = 2'd1;
    localparam state_t ST_DISCARD = 2'd2;

    // Bytes carrying one 4-pixel group; zero marks an unsupported type.
    function automatic logic [3:0] group_size(input logic [2:0] pt);
        logic [3:0] g;
        case (pt)
            PT_RAW8:  g = 4'd4;
            PT_RAW10: g = 4'd5;
            PT_RAW12: g = 4'd6;
            PT_RAW14: g = 4'd7;
            default:  g = 4'd0;
        endcase
        return g;
    endfunction

    function automatic logic type_supported(input logic [2:0] pt);
        return group_size(pt) != 4'd0;
    endfunction

endpackage

// File: rtl/mipi_rx_raw_group_decode.sv
// mipi_rx_raw_group_decode: turns one packed byte group into four
// zero-extended 16-bit pixels (bytes_i[7:0] is the first stream byte).
module mipi_rx_raw_group_decode
    import mipi_rx_pkg::*;
(
    input  logic [55:0] bytes_i,
    input  logic [2:0]  type_i,
    output logic [63:0] pixels_o
);

    logic [7:0]  b [7];
    logic [23:0] l14;

    // Split the group into individual bytes.
    always_comb begin
        for (int i = 0; i < 7; i++) begin
            b[i] = bytes_i[8*i +: 8];
        end
    end

    assign l14 = {b[6], b[5], b[4]};

    // Per-type pixel reassembly: MSBs from the lead bytes, LSBs from the tail.
    always_comb begin
        pixels_o = '0;
        case (type_i)
            PT_RAW8: begin
                for (int k = 0; k < 4; k++) begin
                    pixels_o[16*k +: 16] = {8'd0, b[k]};
                end
            end
            PT_RAW10: begin
                for (int k = 0; k < 4; k++) begin
                    pixels_o[16*k +: 16] = {6'd0, b[k], b[4][2*k +: 2]};
                end
            end
            PT_RAW12: begin
                pixels_o[15:0]  = {4'd0, b[0], b[2][3:0]};
                pixels_o[31:16] = {4'd0, b[1], b[2][7:4]};
                pixels_o[47:32] = {4'd0, b[3], b[5][3:0]};
                pixels_o[63:48] = {4'd0, b[4], b[5][7:4]};
            end
            PT_RAW14: begin
                for (int k = 0; k < 4; k++) begin
                    pixels_o[16*k +: 16] = {2'd0, b[k], l14[6*k +: 6]};
                end
            end
            default: pixels_o = '0;
        endcase
    end

endmodule

// File: rtl/mipi_rx_raw_unpacker.sv
// mipi_rx_raw_unpacker: CSI-2 RAW8/10/12/14 line payload to 4-pixel groups.
// Optional per-line pixel count with MIPI_RX_UNPACK_LINE_STATS_EN.
module mipi_rx_raw_unpacker
    import mipi_rx_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               data_valid_i,
    input  logic [8*LANES-1:0] data_i,
    input  logic [2:0]         packet_type_i,
    output logic               output_valid_o,
    output logic [63:0]        output_o,
    output logic               residue_err_o,
    output logic               type_err_o
`ifdef MIPI_RX_UNPACK_LINE_STATS_EN
    ,
    output logic [15:0]        line_pixels_o,
    output logic               line_done_o
`endif
);

    localparam int         BUF_W   = 96;
    localparam logic [3:0] LANES_W = 4'(LANES);

    state_t             state_q, state_d;
    logic [BUF_W-1:0]   buf_q, buf_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [2:0]         type_q, type_d;
    logic [2:0]         cur_type;
    logic [3:0]         gsize;
    logic [3:0]         total;
    logic [BUF_W-1:0]   merged;
    logic               take;
    logic               grp_fire;
    logic               res_err_d;
    logic               typ_err_d;
    logic [63:0]        pix;

    // The first beat of a line decodes with the live type; later beats use the latch.
    assign cur_type = (state_q == ST_IDLE) ? packet_type_i : type_q;
    assign gsize    = group_size(cur_type);
    assign merged   = buf_q | (BUF_W'(data_i) << {cnt_q, 3'b000});
    assign total    = cnt_q + LANES_W;

    // Line FSM plus buffer append / single-group extraction.
    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        cnt_d     = cnt_q;
        type_d    = type_q;
        take      = 1'b0;
        grp_fire  = 1'b0;
        res_err_d = 1'b0;
        typ_err_d = 1'b0;
        unique case (1'b1)
            (state_q == ST_IDLE): begin
                if (data_valid_i) begin
                    if (type_supported(packet_type_i)) begin
                        state_d = ST_ACTIVE;
                        type_d  = packet_type_i;
                        take    = 1'b1;
                    end else begin
                        state_d   = ST_DISCARD;
                        typ_err_d = 1'b1;
                    end
                end
            end
            (state_q == ST_ACTIVE): begin
                if (data_valid_i) begin
                    take = 1'b1;
                end else begin
                    state_d   = ST_IDLE;
                    buf_d     = '0;
                    cnt_d     = '0;
                    res_err_d = (cnt_q != 4'd0);
                end
            end
            (state_q == ST_DISCARD): begin
                if (!data_valid_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (take) begin
            if (total >= gsize) begin
                grp_fire = 1'b1;
                buf_d    = merged >> {gsize, 3'b000};
                cnt_d    = total - gsize;
            end else begin
                buf_d = merged;
                cnt_d = total;
            end
        end
    end

    mipi_rx_raw_group_decode u_decode (
        .bytes_i  (merged[55:0]),
        .type_i   (cur_type),
        .pixels_o (pix)
    );

    // Line state, byte buffer and latched packet type.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            buf_q   <= '0;
            cnt_q   <= '0;
            type_q  <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            type_q  <= type_d;
        end
    end

    // Registered pixel output and error pulses; output is zero when not valid.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            output_valid_o <= 1'b0;
            output_o       <= '0;
            residue_err_o  <= 1'b0;
            type_err_o     <= 1'b0;
        end else begin
            output_valid_o <= grp_fire;
            output_o       <= grp_fire ? pix : 64'd0;
            residue_err_o  <= res_err_d;
            type_err_o     <= typ_err_d;
        end
    end

`ifdef MIPI_RX_UNPACK_LINE_STATS_EN
    logic        line_end;
    logic [15:0] pix_cnt_q;

    assign line_end = (state_q == ST_ACTIVE) && !data_valid_i;

    // Saturating pixel count per line, published when the line closes.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pix_cnt_q     <= '0;
            line_pixels_o <= '0;
            line_done_o   <= 1'b0;
        end else begin
            line_done_o <= line_end;
            if (line_end) begin
                line_pixels_o <= pix_cnt_q;
                pix_cnt_q     <= '0;
            end else if (grp_fire) begin
                pix_cnt_q <= (pix_cnt_q > 16'hFFFB) ? 16'hFFFF : pix_cnt_q + 16'd4;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mipi_rx_raw_unpacker.sv
// tb_mipi_rx_raw_unpacker: directed and random lines on a 4-lane and a
// 1-lane instance, compared against a byte-queue model of the pixel rules.
`timescale 1ns/1ps
module tb_mipi_rx_raw_unpacker;

    logic        clk;
    logic        rst;
    logic        v4, v1;
    logic [31:0] d4;
    logic [7:0]  d1;
    logic [2:0]  pt;
    logic        ov4, re4, te4;
    logic        ov1, re1, te1;
    logic [63:0] o4, o1;
`ifdef MIPI_RX_UNPACK_LINE_STATS_EN
    logic [15:0] lp4, lp1;
    logic        ld4, ld1;
`endif

    mipi_rx_raw_unpacker #(.LANES(4)) dut4 (
        .clk_i          (clk),
        .reset_i        (rst),
        .data_valid_i   (v4),
        .data_i         (d4),
        .packet_type_i  (pt),
        .output_valid_o (ov4),
        .output_o       (o4),
        .residue_err_o  (re4),
        .type_err_o     (te4)
`ifdef MIPI_RX_UNPACK_LINE_STATS_EN
        ,
        .line_pixels_o  (lp4),
        .line_done_o    (ld4)
`endif
    );

    mipi_rx_raw_unpacker #(.LANES(1)) dut1 (
        .clk_i          (clk),
        .reset_i        (rst),
        .data_valid_i   (v1),
        .data_i         (d1),
        .packet_type_i  (pt),
        .output_valid_o (ov1),
        .output_o       (o1),
        .residue_err_o  (re1),
        .type_err_o     (te1)
`ifdef MIPI_RX_UNPACK_LINE_STATS_EN
        ,
        .line_pixels_o  (lp1),
        .line_done_o    (ld1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] cyc;
        logic [63:0] d;
    } ev_t;

    ev_t  mon_q[$];
    ev_t  exp_q[$];
    int   mon_res[$];
    int   exp_res[$];
    int   mon_te[$];
    int   exp_te[$];
    int   cyc;
    int   n_chk;
    int   n_fail;

    int       m_sel;
    int       m_lanes;
    logic [2:0] m_typ;
    bit       m_sup;
    bit       m_first;
    int       m_bytes[$];
    int       m_emit;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ov4) mon_q.push_back({32'(cyc), o4});
        if (ov1) mon_q.push_back({32'(cyc), o1});
        if (re4 || re1) mon_res.push_back(cyc);
        if (te4 || te1) mon_te.push_back(cyc);
    end

    function automatic int gsz(input logic [2:0] t);
        case (t)
            3'd2: return 4;
            3'd3: return 5;
            3'd4: return 6;
            3'd5: return 7;
            default: return 0;
        endcase
    endfunction

    function automatic logic [63:0] ref_pix(input logic [2:0] t, input int b[7]);
        logic [63:0] r;
        int p;
        int l;
        r = '0;
        l = b[4] + 256 * b[5] + 65536 * b[6];
        for (int k = 0; k < 4; k++) begin
            case (t)
                3'd2: p = b[k];
                3'd3: p = b[k] * 4 + ((b[4] >> (2 * k)) % 4);
                3'd4: p = (k < 2) ? b[k] * 16 + ((b[2] >> (4 * k)) % 16)
                                  : b[k+1] * 16 + ((b[5] >> (4 * (k - 2))) % 16);
                3'd5: p = b[k] * 64 + ((l >> (6 * k)) % 64);
                default: p = 0;
            endcase
            r[16*k +: 16] = 16'(p);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_ev(input string tag, input int idx, input logic [63:0] val);
        logic [63:0] obs;
        obs = (idx < mon_q.size()) ? mon_q[idx].d : ~val;
        chk(tag, obs, val);
    endtask

    task automatic start_line(input int sel);
        m_sel   = sel;
        m_lanes = (sel == 0) ? 4 : 1;
        m_first = 1'b1;
        m_sup   = 1'b0;
        m_emit  = 0;
        m_bytes.delete();
    endtask

    task automatic beat(input logic [2:0] t, input logic [31:0] d);
        int g;
        int base;
        int arr[7];
        @(negedge clk);
        pt = t;
        if (m_sel == 0) begin
            v4 = 1'b1;
            d4 = d;
        end else begin
            v1 = 1'b1;
            d1 = d[7:0];
        end
        if (m_first) begin
            m_first = 1'b0;
            m_typ   = t;
            m_sup   = (gsz(t) != 0);
            if (!m_sup) exp_te.push_back(cyc + 1);
        end
        if (m_sup) begin
            for (int j = 0; j < m_lanes; j++) begin
                m_bytes.push_back(int'((d >> (8 * j)) & 32'hFF));
            end
            g = gsz(m_typ);
            if (m_bytes.size() / g > m_emit) begin
                base = m_emit * g;
                for (int j = 0; j < 7; j++) begin
                    arr[j] = (base + j < m_bytes.size()) ? m_bytes[base + j] : 0;
                end
                exp_q.push_back({32'(cyc + 1), ref_pix(m_typ, arr)});
                m_emit++;
            end
        end
    endtask

    task automatic end_line(input int idle);
        @(negedge clk);
        v4 = 1'b0;
        v1 = 1'b0;
        if (m_sup && (m_bytes.size() % gsz(m_typ)) != 0) exp_res.push_back(cyc + 1);
        repeat (idle) @(negedge clk);
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        int n;
        chk({tag, "/groups"}, 64'(mon_q.size()), 64'(exp_q.size()));
        n = (mon_q.size() < exp_q.size()) ? mon_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "/cyc"}, 64'(mon_q[i].cyc), 64'(exp_q[i].cyc));
            chk({tag, "/pix"}, mon_q[i].d, exp_q[i].d);
        end
        chk({tag, "/res_n"}, 64'(mon_res.size()), 64'(exp_res.size()));
        n = (mon_res.size() < exp_res.size()) ? mon_res.size() : exp_res.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "/res_cyc"}, 64'(mon_res[i]), 64'(exp_res[i]));
        end
        chk({tag, "/terr_n"}, 64'(mon_te.size()), 64'(exp_te.size()));
        n = (mon_te.size() < exp_te.size()) ? mon_te.size() : exp_te.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "/terr_cyc"}, 64'(mon_te[i]), 64'(exp_te[i]));
        end
        mon_q.delete();
        exp_q.delete();
        mon_res.delete();
        exp_res.delete();
        mon_te.delete();
        exp_te.delete();
    endtask

    task automatic rand_line(input int sel);
        logic [2:0] t;
        logic [2:0] bad [4];
        int r;
        int nb;
        bad[0] = 3'd0;
        bad[1] = 3'd1;
        bad[2] = 3'd6;
        bad[3] = 3'd7;
        r = $urandom_range(0, 9);
        t = (r < 8) ? 3'(2 + (r % 4)) : bad[$urandom_range(0, 3)];
        nb = $urandom_range(1, 12);
        start_line(sel);
        for (int i = 0; i < nb; i++) begin
            beat((i == 0) ? t : 3'($urandom_range(0, 7)), $urandom);
        end
        end_line($urandom_range(0, 2));
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst = 1'b1;
        v4  = 1'b0;
        v1  = 1'b0;
        d4  = '0;
        d1  = '0;
        pt  = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ov4", 64'(ov4), 64'd0);
        chk("rst_o4",  o4, 64'd0);
        chk("rst_re4", 64'(re4), 64'd0);
        chk("rst_te4", 64'(te4), 64'd0);
        chk("rst_o1",  o1, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        start_line(0);
        beat(3'd3, 32'h78563412);
        beat(3'd3, 32'h000000E4);
        end_line(0);
        settle();
        chk_ev("raw10_pix", 0, 64'h01E3_015A_00D1_0048);
        chk("raw10_res", 64'(mon_res.size()), 64'd1);
        check_all("raw10");

        start_line(0);
        beat(3'd4, 32'hEF21CDAB);
        beat(3'd4, 32'h00004301);
        end_line(0);
        settle();
        chk_ev("raw12_pix", 0, 64'h0014_0EF3_0CD2_0AB1);
        chk("raw12_res", 64'(mon_res.size()), 64'd1);
        check_all("raw12");

        start_line(1);
        beat(3'd2, 32'h11);
        beat(3'd2, 32'h22);
        beat(3'd2, 32'h33);
        beat(3'd2, 32'h44);
        end_line(0);
        settle();
        chk_ev("raw8_l1_pix", 0, 64'h0044_0033_0022_0011);
        chk("raw8_l1_res", 64'(mon_res.size()), 64'd0);
        check_all("raw8_l1");

        start_line(0);
        repeat (7) beat(3'd5, 32'hFFFFFFFF);
        end_line(0);
        settle();
        chk("raw14_n", 64'(mon_q.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk_ev("raw14_pix", i, 64'h3FFF_3FFF_3FFF_3FFF);
        end
        check_all("raw14");

        start_line(0);
        repeat (5) beat(3'd7, $urandom);
        end_line(0);
        start_line(0);
        beat(3'd3, 32'h78563412);
        beat(3'd3, 32'h000000E4);
        end_line(0);
        settle();
        chk("bad_terr", 64'(mon_te.size()), 64'd1);
        chk_ev("bad_next", 0, 64'h01E3_015A_00D1_0048);
        check_all("badtype");

        start_line(0);
        beat(3'd3, $urandom);
        beat(3'd3, $urandom);
        beat(3'd3, $urandom);
        @(negedge clk);
        #1;
        rst = 1'b1;
        v4  = 1'b0;
        #1;
        chk("mid_rst_ov", 64'(ov4), 64'd0);
        chk("mid_rst_o",  o4, 64'd0);
        chk("mid_rst_re", 64'(re4), 64'd0);
        chk("mid_rst_te", 64'(te4), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        settle();
        check_all("midrst");
        start_line(0);
        beat(3'd3, 32'h78563412);
        beat(3'd3, 32'h000000E4);
        end_line(0);
        settle();
        chk_ev("post_rst", 0, 64'h01E3_015A_00D1_0048);
        check_all("postrst");

        for (int n = 0; n < 60; n++) begin
            rand_line($urandom_range(0, 1));
            if (n % 4 == 3) begin
                settle();
                check_all("rand");
            end
        end
        settle();
        check_all("rand_end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mipi_rx_raw_unpacker.md
MIPI_RX_RAW_UNPACKER -- requirements
Module: mipi_rx_raw_unpacker

Interface
REQ-001 SHALL have parameter LANES, default 4, meaning CSI byte lanes per beat; legal values 1, 2, 4.
REQ-002 SHALL have port clk_i  input  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have port reset_i  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port data_valid_i  input  1  line payload beat valid; low marks end of line.
REQ-005 SHALL have port data_i  input  8*LANES  payload bytes; stream byte order is data_i[7:0] first.
REQ-006 SHALL have port packet_type_i  input  3  2=RAW8, 3=RAW10, 4=RAW12, 5=RAW14; other codes unsupported.
REQ-007 SHALL have port output_valid_o  output  1  output_o holds one 4-pixel group.
REQ-008 SHALL have port output_o  output  64  pixel k at [16k+15:16k], LSB-aligned, zero-extended.
REQ-009 SHALL have port residue_err_o  output  1  one-cycle pulse: line ended with a partial group.
REQ-010 SHALL have port type_err_o  output  1  one-cycle pulse: line started with an unsupported type.

Function
REQ-011 SHALL implement FSM IDLE, ACTIVE, DISCARD.
- IDLE->ACTIVE on data_valid_i=1 with a supported type.
- IDLE->DISCARD on data_valid_i=1 with an unsupported type.
- ACTIVE/DISCARD->IDLE on data_valid_i=0.
REQ-012 SHALL latch packet_type_i on the IDLE->ACTIVE beat; changes while ACTIVE are ignored until the next line.
REQ-013 SHALL use group size G bytes: RAW8=4, RAW10=5, RAW12=6, RAW14=7; each group yields 4 pixels.
REQ-014 SHALL append each valid beat to a byte buffer of at least 12 bytes; residual after extraction is always < G.
REQ-015 SHALL extract at most one group per cycle, lowest-order bytes first; because G >= 4 >= LANES, no input stall is ever needed.
REQ-016 SHALL decode bytes B0..B(G-1) of a group as follows.
- RAW8: Pk=Bk.
- RAW10: Pk={Bk, B4[2k+1:2k]}.
- RAW12: P0={B0,B2[3:0]}, P1={B1,B2[7:4]}, P2={B3,B5[3:0]}, P3={B4,B5[7:4]}.
- RAW14: Pk={Bk, L[6k+5:6k]}, where L={B6,B5,B4}.
REQ-017 SHALL assert output_valid_o, registered, exactly 1 cycle after the beat that completes a group; the output holds no value otherwise.
REQ-018 SHALL, on data_valid_i falling while ACTIVE, clear the buffer in that cycle.
- Residual count nonzero: pulse residue_err_o in the following cycle and emit no partial group.
- A group completed by the last beat is still emitted.
REQ-019 SHALL, on entering DISCARD, pulse type_err_o once and produce no output_valid_o until IDLE.
REQ-020 SHALL accept a new line in the cycle immediately after data_valid_i returns low (a single idle cycle is enough between lines).

Reset
REQ-021 SHALL, while reset_i=1, force: FSM=IDLE; buffer, byte count and latched type =0; output_valid_o=0, output_o=0, residue_err_o=0, type_err_o=0.
REQ-022 SHALL discard a partially received line on reset assertion mid-line, with no error pulse.

Configuration
REQ-023 SHALL, with MIPI_RX_UNPACK_LINE_STATS_EN defined, add two outputs.
- line_pixels_o (output, 16 bits): pixels emitted in the last completed line, saturating at 16'hFFFF, reset 0.
- line_done_o: one-cycle pulse coincident with the cycle that updates line_pixels_o.
REQ-024 SHALL, without MIPI_RX_UNPACK_LINE_STATS_EN, omit both ports and their logic; all other behaviour is identical.

Structure
REQ-025 SHALL place the packet-type codes, the group-size-per-type function and the FSM state type in a shared package, mipi_rx_pkg.
REQ-026 SHALL implement group-to-pixel decoding as the combinational sub-module mipi_rx_raw_group_decode (inputs: 7 bytes and type; output: 64-bit pixels).

Verification
REQ-027 SHALL cover RAW10, LANES=4: beats 32'h78563412 then 32'h000000E4, then valid low -> one output_valid_o, output_o=64'h01E3_015A_00D1_0048, then residue_err_o pulse (3 residual bytes).
REQ-028 SHALL cover RAW12, LANES=4: beats 32'hEF21CDAB then 32'h00004301 -> output_o=64'h0014_0EF3_0CD2_0AB1, then residue_err_o pulse (2 residual bytes).
REQ-029 SHALL cover RAW8, LANES=1: bytes 11,22,33,44 -> output_o=64'h0044_0033_0022_0011 one cycle after the 4th beat; no residue_err_o.
REQ-030 SHALL cover RAW14, LANES=4: 7 beats of 32'hFFFFFFFF -> 4 groups of 64'h3FFF_3FFF_3FFF_3FFF, no residue_err_o.
REQ-031 SHALL cover packet_type_i=7 for 5 beats -> type_err_o pulses once, no output_valid_o; the next RAW10 line decodes correctly.
REQ-032 SHALL cover reset_i asserted after 3 beats of a RAW10 line -> all outputs 0 and no pulses; the next line decodes from byte 0.
